// File: rtl/bullet_engine.sv
// bullet_engine: one projectile per player -- spawn at the tank, one move per video frame,
// tile-map lookup and hit resolution. Optional enemy-tank collision: define BULLET_TANK_HIT_EN.
module bullet_engine #(
  parameter int SPEED      = 4,
  parameter int MAP_W      = 20,
  parameter int MAP_H      = 15,
  parameter int TILE_SHIFT = 5,
  parameter int TANK_SIZE  = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_vs,
  input  logic       fire,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] TankDir,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  output logic [8:0] tile_addr,
  input  logic [2:0] tile_data,
  output logic       wr_valid,
  output logic [8:0] wr_addr,
  input  logic       wr_ready,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic       BulletActive,
  output logic [1:0] base_hit,
  output logic       tank_hit
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVE, S_MOVE, S_LOOKUP, S_RESOLVE, S_WRITE
  } state_t;

  localparam logic signed [10:0] SPD      = 11'(SPEED);
  localparam logic [10:0]        MAP_COLS = 11'(MAP_W);
  localparam logic [10:0]        MAP_ROWS = 11'(MAP_H);
  localparam logic [10:0]        TANK_SZ  = 11'(TANK_SIZE);

  state_t     state, state_d;
  logic       vs_meta, vs_sync, vs_prev, frame_tick, fire_q;
  logic       fire_edge;
  logic [1:0] dir_q, dir_d;
  logic [9:0] nx_q, ny_q, nx_d, ny_d, bx_d, by_d;
  logic       act_d, wrv_d, th_d;
  logic [8:0] wra_d;
  logic [1:0] bh_d;

  assign fire_edge = fire & ~fire_q;

  // Tile index of the candidate position's centre (sprite is 4x4, centre = +2).
  logic [10:0] cen_x, cen_y, col, row, addr_full;
  assign cen_x     = {1'b0, nx_q} + 11'd2;
  assign cen_y     = {1'b0, ny_q} + 11'd2;
  assign col       = cen_x >> TILE_SHIFT;
  assign row       = cen_y >> TILE_SHIFT;
  assign addr_full = row * MAP_COLS + col;
  assign tile_addr = addr_full[8:0];

  logic [9:0] ctr_x, ctr_y, spawn_x, spawn_y;
  assign ctr_x = TankX + 10'd14;
  assign ctr_y = TankY + 10'd14;

  always_comb begin
    spawn_x = ctr_x;
    spawn_y = ctr_y;
    unique case (TankDir)
      2'd0: spawn_y = ctr_y - 10'd16;
      2'd1: spawn_x = ctr_x + 10'd16;
      2'd2: spawn_y = ctr_y + 10'd16;
      2'd3: spawn_x = ctr_x - 10'd16;
      default: ;
    endcase
  end

  // Candidate position in signed 11 bits so stepping past 0 shows up as negative.
  logic signed [10:0] mv_x, mv_y;
  logic               oob;
  always_comb begin
    mv_x = $signed({1'b0, BulletX});
    mv_y = $signed({1'b0, BulletY});
    unique case (dir_q)
      2'd0: mv_y = mv_y - SPD;
      2'd1: mv_x = mv_x + SPD;
      2'd2: mv_y = mv_y + SPD;
      2'd3: mv_x = mv_x - SPD;
      default: ;
    endcase
    oob = mv_x[10] || mv_y[10] || (mv_x > 11'sd639) || (mv_y > 11'sd479);
  end

  logic enemy_hit;
  logic unused_cfg;
`ifdef BULLET_TANK_HIT_EN
  assign enemy_hit = ({1'b0, nx_q} < ({1'b0, EnemyX} + TANK_SZ)) &&
                     (({1'b0, nx_q} + 11'd4) > {1'b0, EnemyX}) &&
                     ({1'b0, ny_q} < ({1'b0, EnemyY} + TANK_SZ)) &&
                     (({1'b0, ny_q} + 11'd4) > {1'b0, EnemyY});
  assign unused_cfg = ^{MAP_ROWS, addr_full[10:9]};
`else
  assign enemy_hit  = 1'b0;
  assign unused_cfg = ^{MAP_ROWS, TANK_SZ, EnemyX, EnemyY, addr_full[10:9]};
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state;
    dir_d   = dir_q;
    bx_d    = BulletX;
    by_d    = BulletY;
    act_d   = BulletActive;
    nx_d    = nx_q;
    ny_d    = ny_q;
    wrv_d   = wr_valid;
    wra_d   = wr_addr;
    bh_d    = 2'b00;
    th_d    = 1'b0;
    unique case (state)
      S_IDLE: if (fire_edge) begin
        bx_d    = spawn_x;
        by_d    = spawn_y;
        dir_d   = TankDir;
        act_d   = 1'b1;
        state_d = S_ACTIVE;
      end
      S_ACTIVE: if (frame_tick) state_d = S_MOVE;
      S_MOVE: begin
        if (oob) begin
          act_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          nx_d    = mv_x[9:0];
          ny_d    = mv_y[9:0];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_RESOLVE;
      S_RESOLVE: begin
        act_d   = 1'b0;
        state_d = S_IDLE;
        if (enemy_hit) begin
          th_d = 1'b1;
        end else begin
          case (tile_data)
            3'd0: begin
              bx_d    = nx_q;
              by_d    = ny_q;
              act_d   = 1'b1;
              state_d = S_ACTIVE;
            end
            3'd2: begin
              wrv_d   = 1'b1;
              wra_d   = tile_addr;
              act_d   = 1'b1;
              state_d = S_WRITE;
            end
            3'd3:    bh_d = 2'b01;
            3'd4:    bh_d = 2'b10;
            default: ;
          endcase
        end
      end
      S_WRITE: if (wr_ready) begin
        wrv_d   = 1'b0;
        act_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      vs_meta      <= 1'b0;
      vs_sync      <= 1'b0;
      vs_prev      <= 1'b0;
      frame_tick   <= 1'b0;
      fire_q       <= 1'b0;
      dir_q        <= 2'd0;
      nx_q         <= 10'd0;
      ny_q         <= 10'd0;
      BulletX      <= 10'd0;
      BulletY      <= 10'd0;
      BulletActive <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= 9'd0;
      base_hit     <= 2'b00;
      tank_hit     <= 1'b0;
    end else begin
      state        <= state_d;
      vs_meta      <= frame_vs;
      vs_sync      <= vs_meta;
      vs_prev      <= vs_sync;
      frame_tick   <= vs_sync & ~vs_prev;
      fire_q       <= fire;
      dir_q        <= dir_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      BulletX      <= bx_d;
      BulletY      <= by_d;
      BulletActive <= act_d;
      wr_valid     <= wrv_d;
      wr_addr      <= wra_d;
      base_hit     <= bh_d;
      tank_hit     <= th_d;
    end
  end

endmodule

// File: tb/tb_bullet_engine.sv
// tb_bullet_engine: table-driven spawn/move vectors plus directed wall, base, reset and tank sequences.
module tb_bullet_engine;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_vs = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] TankX = '0, TankY = '0;
  logic [1:0] TankDir = '0;
  logic [9:0] EnemyX = 10'd1000, EnemyY = 10'd1000;
  logic [8:0] tile_addr;
  logic [2:0] tile_data;
  logic       wr_valid;
  logic [8:0] wr_addr;
  logic       wr_ready = 1'b1;
  logic [9:0] BulletX, BulletY;
  logic       BulletActive;
  logic [1:0] base_hit;
  logic       tank_hit;

  always #5 Clk = ~Clk;

  bullet_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_vs(frame_vs), .fire(fire),
    .TankX(TankX), .TankY(TankY), .TankDir(TankDir),
    .EnemyX(EnemyX), .EnemyY(EnemyY),
    .tile_addr(tile_addr), .tile_data(tile_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_ready(wr_ready),
    .BulletX(BulletX), .BulletY(BulletY), .BulletActive(BulletActive),
    .base_hit(base_hit), .tank_hit(tank_hit)
  );

  // Map model: registered read (1 Clk latency), bench pokes and DUT clear-writes.
  logic [2:0] map [0:511];
  logic       map_clr = 1'b1, poke_en = 1'b0;
  logic [8:0] poke_addr = '0;
  logic [2:0] poke_val = '0;
  int         wr_cnt = 0;

  always @(posedge Clk) begin
    tile_data <= map[tile_addr];
    if (map_clr) begin
      for (int i = 0; i < 512; i++) map[i] <= 3'd0;
    end else if (poke_en) begin
      map[poke_addr] <= poke_val;
    end
    if (wr_valid && wr_ready) begin
      map[wr_addr] <= 3'd0;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int bh1_cnt = 0, bh2_cnt = 0, th_cnt = 0;
  always @(negedge Clk) begin
    if (base_hit[0]) bh1_cnt++;
    if (base_hit[1]) bh2_cnt++;
    if (tank_hit)    th_cnt++;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; fire = 1'b0; frame_vs = 1'b0; wr_ready = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(2);
  endtask

  task automatic poke(input logic [8:0] a, input logic [2:0] v);
    poke_addr = a; poke_val = v; poke_en = 1'b1;
    tick(1);
    poke_en = 1'b0;
  endtask

  task automatic press_fire(input logic hold);
    fire = 1'b0;
    tick(1);
    fire = 1'b1;
    tick(2);
    if (!hold) fire = 1'b0;
    tick(1);
  endtask

  task automatic frame();
    frame_vs = 1'b1;
    tick(3);
    frame_vs = 1'b0;
    tick(10);
  endtask

  task automatic set_tank(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
    TankX = x; TankY = y; TankDir = d;
  endtask

  typedef struct {
    logic [9:0] tx, ty;
    logic [1:0] dir;
    logic [9:0] sx, sy;
    logic       act1;
    logic [9:0] mx, my;
  } vec_t;

  vec_t vecs [9];

  int s1, s2, w0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Spawn at centre+16 in TankDir, then one move of 4 px with an empty map.
    vecs[0] = '{tx:64,  ty:64,  dir:1, sx:94,  sy:78,  act1:1, mx:98,  my:78};
    vecs[1] = '{tx:200, ty:100, dir:0, sx:214, sy:98,  act1:1, mx:214, my:94};
    vecs[2] = '{tx:300, ty:200, dir:2, sx:314, sy:230, act1:1, mx:314, my:234};
    vecs[3] = '{tx:300, ty:200, dir:3, sx:298, sy:214, act1:1, mx:294, my:214};
    vecs[4] = '{tx:100, ty:4,   dir:0, sx:114, sy:2,   act1:0, mx:114, my:2};
    vecs[5] = '{tx:606, ty:64,  dir:1, sx:636, sy:78,  act1:0, mx:636, my:78};
    vecs[6] = '{tx:605, ty:64,  dir:1, sx:635, sy:78,  act1:1, mx:639, my:78};
    vecs[7] = '{tx:100, ty:446, dir:2, sx:114, sy:476, act1:0, mx:114, my:476};
    vecs[8] = '{tx:2,   ty:64,  dir:3, sx:0,   sy:78,  act1:0, mx:0,   my:78};

    tick(2);
    check("rst_active",    BulletActive, 0);
    check("rst_x",         BulletX, 0);
    check("rst_y",         BulletY, 0);
    check("rst_wr_valid",  wr_valid, 0);
    check("rst_wr_addr",   wr_addr, 0);
    check("rst_base_hit",  base_hit, 0);
    check("rst_tank_hit",  tank_hit, 0);
    check("rst_tile_addr", tile_addr, 0);
    map_clr = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_reset();
      set_tank(vecs[i].tx, vecs[i].ty, vecs[i].dir);
      press_fire(1'b0);
      check($sformatf("v%0d_spawn_act", i), BulletActive, 1);
      check($sformatf("v%0d_spawn_x", i), BulletX, vecs[i].sx);
      check($sformatf("v%0d_spawn_y", i), BulletY, vecs[i].sy);
      frame();
      check($sformatf("v%0d_move_act", i), BulletActive, vecs[i].act1);
      check($sformatf("v%0d_move_x", i), BulletX, vecs[i].mx);
      check($sformatf("v%0d_move_y", i), BulletY, vecs[i].my);
    end

    // Three frames from X=94 moving right, then a re-press while in flight is ignored.
    do_reset();
    set_tank(64, 64, 1);
    press_fire(1'b0);
    frame(); check("run_x1", BulletX, 98);
    frame(); check("run_x2", BulletX, 102);
    frame(); check("run_x3", BulletX, 106);
    set_tank(300, 300, 0);
    press_fire(1'b0);
    check("refire_x", BulletX, 106);
    check("refire_y", BulletY, 78);
    check("refire_act", BulletActive, 1);

    // Destructible wall at index 29 with a 4-cycle write stall.
    do_reset();
    poke(9'd29, 3'd2);
    wr_ready = 1'b0;
    set_tank(250, 30, 1);
    press_fire(1'b0);
    check("wall_spawn_x", BulletX, 280);
    frame();
    check("wall_pre_x", BulletX, 284);
    check("wall_pre_wr", wr_valid, 0);
    frame();
    w0 = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wall_stall%0d_valid", k), wr_valid, 1);
      check($sformatf("wall_stall%0d_addr", k), wr_addr, 29);
      tick(1);
    end
    wr_ready = 1'b1;
    tick(1);
    check("wall_done_valid", wr_valid, 0);
    check("wall_done_act", BulletActive, 0);
    check("wall_handshakes", wr_cnt - w0, 1);
    check("wall_tile_cleared", map[29], 0);
    press_fire(1'b0);
    check("wall_idle_respawn", BulletActive, 1);

    // P1 base with fire held: one pulse, no respawn until released and re-pressed.
    do_reset();
    poke(9'd43, 3'd3);
    set_tank(64, 64, 1);
    press_fire(1'b1);
    check("base1_spawn_act", BulletActive, 1);
    s1 = bh1_cnt; s2 = bh2_cnt;
    frame();
    check("base1_p1_pulses", bh1_cnt - s1, 1);
    check("base1_p2_pulses", bh2_cnt - s2, 0);
    check("base1_act", BulletActive, 0);
    frame();
    check("base1_held_no_spawn", BulletActive, 0);
    press_fire(1'b0);
    check("base1_repress_spawn", BulletActive, 1);

    // P2 base.
    do_reset();
    poke(9'd43, 3'd4);
    press_fire(1'b0);
    s1 = bh1_cnt; s2 = bh2_cnt;
    frame();
    check("base2_p1_pulses", bh1_cnt - s1, 0);
    check("base2_p2_pulses", bh2_cnt - s2, 1);
    check("base2_act", BulletActive, 0);

    // Indestructible wall (tile 1) and reserved tile (6) both just stop the bullet.
    do_reset();
    poke(9'd43, 3'd1);
    press_fire(1'b0);
    frame();
    check("wall1_act", BulletActive, 0);
    check("wall1_no_write", wr_valid, 0);
    do_reset();
    poke(9'd43, 3'd6);
    press_fire(1'b0);
    frame();
    check("tile6_act", BulletActive, 0);

    // Reset asserted while a write is pending.
    do_reset();
    poke(9'd43, 3'd0);
    poke(9'd29, 3'd2);
    wr_ready = 1'b0;
    set_tank(250, 30, 1);
    press_fire(1'b0);
    frame();
    frame();
    check("rstw_pending", wr_valid, 1);
    w0 = wr_cnt;
    #2 Reset = 1'b1;
    #1;
    check("rstw_wr_valid", wr_valid, 0);
    check("rstw_wr_addr", wr_addr, 0);
    check("rstw_act", BulletActive, 0);
    check("rstw_x", BulletX, 0);
    check("rstw_y", BulletY, 0);
    tick(2);
    Reset = 1'b0;
    wr_ready = 1'b1;
    tick(2);
    check("rstw_no_write", wr_cnt - w0, 0);
    check("rstw_tile_kept", map[29], 2);

    // Enemy tank at (120,64); bullet moving right from X=110.
    do_reset();
    poke(9'd29, 3'd0);
    EnemyX = 10'd120; EnemyY = 10'd64;
    set_tank(80, 56, 1);
    press_fire(1'b0);
    check("tank_spawn_x", BulletX, 110);
    s1 = th_cnt;
    frame();
    check("tank_first_x", BulletX, 114);
    check("tank_first_pulses", th_cnt - s1, 0);
    frame();
`ifdef BULLET_TANK_HIT_EN
    check("tank_hit_pulses", th_cnt - s1, 1);
    check("tank_hit_act", BulletActive, 0);
`else
    check("tank_hit_pulses", th_cnt - s1, 0);
    check("tank_hit_act", BulletActive, 1);
    check("tank_pass_x", BulletX, 118);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
